// File: rtl/life_matrix.sv
// Conway's Game of Life engine on an 8x8 register array.
// Cell (r,c) lives at bit 8*r+c of the grid; 1 = alive.
// load replaces the grid (and clears the generation counter) with priority over en;
// en advances one generation per rising edge. grid is taken straight from the state register.
module life_matrix #(
    parameter logic [63:0] SEED = 64'h0000_0000_0007_0402,
    parameter bit          WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] load_data,
    output logic [63:0] grid,
    output logic [15:0] gen_count
);

    logic [63:0] r_grid;
    logic [15:0] r_gen_count;
    logic [63:0] w_next_grid;

    // State of neighbour (r,c), where r and c may be one step outside the grid.
    // With WRAP the indices fold mod 8; without WRAP off-grid neighbours are dead.
    function automatic logic cell_at(input logic [63:0] g, input int r, input int c);
        int         rr;
        int         cc;
        logic [5:0] idx;
        logic       alive;
        alive = 1'b0;
        if (WRAP) begin
            rr    = (r + 8) % 8;
            cc    = (c + 8) % 8;
            idx   = 6'(8 * rr + cc);
            alive = g[idx];
        end else if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
            idx   = 6'(8 * r + c);
            alive = g[idx];
        end
        return alive;
    endfunction

    // Next generation from the registered grid only; all cells update together.
    always_comb begin
        logic [3:0] n;
        logic [5:0] idx;
        w_next_grid = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            n = n + {3'b000, cell_at(r_grid, r + dr, c + dc)};
                        end
                    end
                end
                idx = 6'(8 * r + c);
                w_next_grid[idx] = (n == 4'd3) || (r_grid[idx] && (n == 4'd2));
            end
        end
    end

    // Grid and generation counter: async reset to SEED, then load > step > hold.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_grid      <= SEED;
            r_gen_count <= 16'd0;
        end else if (load) begin
            r_grid      <= load_data;
            r_gen_count <= 16'd0;
        end else if (en) begin
            r_grid      <= w_next_grid;
            r_gen_count <= r_gen_count + 16'd1;
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_matrix.sv
// Bench for life_matrix: one toroidal and one flat-edged instance share all inputs
// and are compared every cycle against a 2-D array Game of Life model.
module tb_life_matrix;

  localparam logic [63:0] SEED    = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;

  logic        clk;
  logic        clk_run;
  logic        _rst;
  logic        en;
  logic        load;
  logic [63:0] load_data;
  logic [63:0] grid_wrap;
  logic [15:0] gen_wrap;
  logic [63:0] grid_flat;
  logic [15:0] gen_flat;

  int n_checks;
  int n_errors;

  // reference state
  logic [63:0] m_wrap;
  logic [63:0] m_flat;
  logic [15:0] m_gen;
  logic [63:0] exp_q[$];

  life_matrix #(.SEED(SEED), .WRAP(1'b1)) u_wrap (
    .clk(clk), ._rst(_rst), .en(en), .load(load), .load_data(load_data),
    .grid(grid_wrap), .gen_count(gen_wrap)
  );

  life_matrix #(.SEED(SEED), .WRAP(1'b0)) u_flat (
    .clk(clk), ._rst(_rst), .en(en), .load(load), .load_data(load_data),
    .grid(grid_flat), .gen_count(gen_flat)
  );

  // clock / reset block: clock can be held low to test reset without edges
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // one Game of Life generation on an 8x8 board
  function automatic logic [63:0] life_step(input logic [63:0] g, input bit wrap);
    bit cells [8][8];
    logic [63:0] out;
    int n;
    int nr;
    int nc;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        cells[r][c] = ((g >> (8 * r + c)) & 64'd1) != 64'd0;
    out = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            nr = r + dr;
            nc = c + dc;
            if (wrap) begin
              nr = (nr + 8) % 8;
              nc = (nc + 8) % 8;
              n += cells[nr][nc];
            end else if (nr >= 0 && nr < 8 && nc >= 0 && nc < 8) begin
              n += cells[nr][nc];
            end
          end
        end
        if (n == 3 || (cells[r][c] && n == 2))
          out = out | (64'd1 << (8 * r + c));
      end
    end
    return out;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_grid_wrap"}, grid_wrap, m_wrap);
    check({tag, "_gen_wrap"}, {48'd0, gen_wrap}, {48'd0, m_gen});
    check({tag, "_grid_flat"}, grid_flat, m_flat);
    check({tag, "_gen_flat"}, {48'd0, gen_flat}, {48'd0, m_gen});
  endtask

  // driver: apply current inputs to the model, then take one clock edge
  task automatic tick();
    if (load) begin
      m_wrap = load_data;
      m_flat = load_data;
      m_gen  = 16'd0;
    end else if (en) begin
      m_wrap = life_step(m_wrap, 1'b1);
      m_flat = life_step(m_flat, 1'b0);
      m_gen  = m_gen + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    _rst = 1'b0;
    m_wrap = SEED;
    m_flat = SEED;
    m_gen  = 16'd0;
    #1;
    check_both("reset_pulse");
    #1;
    _rst = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    clk_run   = 1'b0;
    _rst      = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    load_data = '0;
    m_wrap    = SEED;
    m_flat    = SEED;
    m_gen     = 16'd0;

    // reset with the clock stopped
    #2 _rst = 1'b0;
    #2;
    check("reset_grid_wrap", grid_wrap, 64'h0000_0000_0007_0402);
    check("reset_gen_wrap", {48'd0, gen_wrap}, 64'd0);
    check("reset_grid_flat", grid_flat, 64'h0000_0000_0007_0402);
    check("reset_gen_flat", {48'd0, gen_flat}, 64'd0);
    #2 _rst = 1'b1;
    #1 clk_run = 1'b1;
    @(posedge clk);
    #1;
    check_both("first_edge_idle");

    // glider from the seed: expected toroidal generations queued up front
    begin
      logic [63:0] g;
      g = SEED;
      for (int i = 0; i < 32; i++) begin
        g = life_step(g, 1'b1);
        exp_q.push_back(g);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("glider_q", grid_wrap, exp_q.pop_front());
      check_both("glider");
    end
    check("glider_back_to_seed", grid_wrap, SEED);
    check("glider_gen32", {48'd0, gen_wrap}, 64'd32);

    // hold with en low
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_both("hold");
    end

    // blinker, loaded with en also high: load wins
    load = 1'b1;
    en = 1'b1;
    load_data = BLINK_H;
    tick();
    check("blink_load", grid_wrap, BLINK_H);
    check("blink_load_gen", {48'd0, gen_wrap}, 64'd0);
    load = 1'b0;
    tick();
    check("blink_step1", grid_wrap, BLINK_V);
    check_both("blink1");
    tick();
    check("blink_step2", grid_wrap, BLINK_H);
    check("blink_gen2", {48'd0, gen_wrap}, 64'd2);
    check_both("blink2");

    // corner block: stable on the torus, dies with dead edges
    load = 1'b1;
    load_data = CORNERS;
    tick();
    load = 1'b0;
    tick();
    check("corner_flat_dead", grid_flat, 64'd0);
    for (int i = 2; i <= 5; i++) tick();
    check("corner_wrap_stable", grid_wrap, CORNERS);
    check("corner_gen5", {48'd0, gen_wrap}, 64'd5);
    check_both("corner");
    // extinct board stays empty while the counter runs
    tick();
    check("extinct_flat", grid_flat, 64'd0);
    check("extinct_gen", {48'd0, gen_flat}, 64'd6);

    // randomized load / enable traffic
    for (int i = 0; i < 300; i++) begin
      load = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      load_data = {$urandom, $urandom};
      tick();
      check_both("random");
    end
    load = 1'b0;

    // mid-run reset: seed, 7 steps, reset between edges, then resume
    pulse_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_both("pre_reset");
    end
    pulse_reset();
    check("midrun_reset_grid", grid_wrap, SEED);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_both("resume");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
